// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock FIFO with a power-of-two depth where every
// slot is usable. Used as the SDRAM controller's command and read-data
// buffer. It has an optional first-word-fall-through read port,
// programmable almost-full/almost-empty levels, and sticky overflow and
// underflow flags.
//
// Ports:
//   clk        single clock, all state updates on posedge
//   clr        synchronous active-high reset; wins over any request
//   wr_req     push wr_data (ignored while full)
//   wr_data    write word
//   rd_req     pop head word (ignored while empty)
//   rd_data    FWFT=0: registered word of last accepted pop
//              FWFT=1: current head word
//   rd_valid   rd_data is meaningful this cycle
//   use_num    occupancy 0..DEPTH
//   wr_full    use_num == DEPTH
//   wr_afull   use_num >= AFULL_LVL
//   rd_empty   use_num == 0
//   rd_aempty  use_num <= AEMPTY_LVL
//   overflow   sticky: write requested while full
//   underflow  sticky: read requested while empty
//
// All status outputs decode registered pointers only, so no request
// input reaches a status output combinationally.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AFULL_LVL  = 14,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH:0]   use_num,
  output logic                  wr_full,
  output logic                  wr_afull,
  output logic                  rd_empty,
  output logic                  rd_aempty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_LVL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_LVL[ADDR_WIDTH:0];

  generate
    if (ADDR_WIDTH < 1 || AEMPTY_LVL < 0 || AEMPTY_LVL >= AFULL_LVL ||
        AFULL_LVL > DEPTH) begin : g_bad_param
      $error("sync_fifo_fwft: illegal ADDR_WIDTH/AFULL_LVL/AEMPTY_LVL");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic                  r_ovf;
  logic                  r_unf;

  logic [ADDR_WIDTH:0]   w_use;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_en;
  logic                  w_rd_en;

  // Extra pointer bit separates full (diff == DEPTH) from empty (diff == 0).
  assign w_use   = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_use == DEPTH_C);
  assign w_empty = (w_use == '0);

  // Accept decisions use pre-edge full/empty only. So a read+write at full
  // pops and drops the write, and at empty pushes and drops the read.
  assign w_wr_en = wr_req & ~w_full  & ~clr;
  assign w_rd_en = rd_req & ~w_empty & ~clr;

  assign use_num   = w_use;
  assign wr_full   = w_full;
  assign rd_empty  = w_empty;
  assign wr_afull  = (w_use >= AFULL_C);
  assign rd_aempty = (w_use <= AEMPTY_C);
  assign overflow  = r_ovf;
  assign underflow = r_unf;

  // Storage is deliberately not cleared by clr.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ovf <= r_ovf | (wr_req & w_full);
      r_unf <= r_unf | (rd_req & w_empty);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always presented; rd_req only acknowledges it.
      assign rd_data  = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
      assign rd_valid = ~w_empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_rd_data;
      logic                  r_rd_valid;

      // One-cycle read latency; data holds its last value between pops.
      always_ff @(posedge clk) begin
        if (clr) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_en;
          if (w_rd_en) r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
        end
      end

      assign rd_data  = r_rd_data;
      assign rd_valid = r_rd_valid;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_fwft.sv
module tb_sync_fifo_fwft;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam int AFL = 6;
  localparam int AEL = 1;

  logic clk = 1'b0;
  logic clr, wr_req, rd_req;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] rd_data_a, rd_data_b;
  logic rd_valid_a, rd_valid_b;
  logic [AW:0] use_a, use_b;
  logic full_a, afull_a, empty_a, aempty_a, ovf_a, unf_a;
  logic full_b, afull_b, empty_b, aempty_b, ovf_b, unf_b;

  always #5 clk = ~clk;

  // Both flavours see identical stimulus; only their read ports differ.
  sync_fifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0),
                   .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)) u_std (
    .clk(clk), .clr(clr), .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .use_num(use_a),
    .wr_full(full_a), .wr_afull(afull_a), .rd_empty(empty_a),
    .rd_aempty(aempty_a), .overflow(ovf_a), .underflow(unf_a));

  sync_fifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1),
                   .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)) u_fwft (
    .clk(clk), .clr(clr), .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .use_num(use_b),
    .wr_full(full_b), .wr_afull(afull_b), .rd_empty(empty_b),
    .rd_aempty(aempty_b), .overflow(ovf_b), .underflow(unf_b));

  // Reference model: a queue of stored words plus sticky flags and the
  // registered read port of the standard-mode FIFO.
  logic [DW-1:0] q[$];
  logic m_ovf, m_unf, m_rdv;
  logic [DW-1:0] m_rdd;

  int n_chk  = 0;
  int n_pass = 0;
  int stepno = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s step %0d: got %h expected %h", tag, stepno, obs, exp);
  endtask

  task automatic model(input logic c, input logic w, input logic [DW-1:0] d, input logic r);
    bit full, empty;
    if (c) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_rdv = 1'b0; m_rdd = '0;
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      if (r && !empty) begin
        m_rdd = q.pop_front();
        m_rdv = 1'b1;
      end else begin
        m_rdv = 1'b0;
      end
      if (w && !full) q.push_back(d);
      if (w && full)  m_ovf = 1'b1;
      if (r && empty) m_unf = 1'b1;
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("use_num_std",  32'(use_a),      32'(n));
    chk("use_num_fwft", 32'(use_b),      32'(n));
    chk("wr_full",      32'(full_a),     32'(n == DEPTH));
    chk("wr_afull",     32'(afull_a),    32'(n >= AFL));
    chk("rd_empty",     32'(empty_a),    32'(n == 0));
    chk("rd_aempty",    32'(aempty_a),   32'(n <= AEL));
    chk("overflow",     32'(ovf_a),      32'(m_ovf));
    chk("underflow",    32'(unf_a),      32'(m_unf));
    chk("overflow_fw",  32'(ovf_b),      32'(m_ovf));
    chk("underflow_fw", 32'(unf_b),      32'(m_unf));
    chk("rd_valid_std", 32'(rd_valid_a), 32'(m_rdv));
    chk("rd_data_std",  32'(rd_data_a),  32'(m_rdd));
    chk("rd_valid_fw",  32'(rd_valid_b), 32'(n != 0));
    if (n != 0) chk("rd_data_fw", 32'(rd_data_b), 32'(q[0]));
  endtask

  task automatic step(input logic c, input logic w, input logic [DW-1:0] d, input logic r);
    clr = c; wr_req = w; wr_data = d; rd_req = r;
    @(posedge clk);
    model(c, w, d, r);
    #1;
    stepno++;
    check_all();
  endtask

  initial begin
    int bias;
    clr = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
    m_ovf = 1'b0; m_unf = 1'b0; m_rdv = 1'b0; m_rdd = '0;

    // Reset state
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("rst_use",   32'(use_a),   32'd0);
    chk("rst_empty", 32'(empty_a), 32'd1);
    chk("rst_afull", 32'(afull_a), 32'd0);

    // Fill then drain in order
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 16'(i), 1'b0);
      if (i == 6) chk("afull_at_6", 32'(afull_a), 32'd1);
    end
    chk("full_at_8", 32'(full_a), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1);
      chk("drain_data", 32'(rd_data_a), 32'(i));
    end

    // Overflow drops the word and sticks until clr
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 16'(i), 1'b0);
    step(1'b0, 1'b1, 16'h00AA, 1'b0);
    chk("ovf_set", 32'(ovf_a), 32'd1);
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("ovf_sticky", 32'(ovf_a), 32'd1);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("ovf_clr", 32'(ovf_a), 32'd0);

    // Simultaneous read+write at full, mid-level and empty
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 16'(16'h10 + i), 1'b0);
    step(1'b0, 1'b1, 16'h0055, 1'b1);
    chk("full_rw_use", 32'(use_a), 32'd7);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b1, 16'h0033, 1'b1);
    chk("mid_rw_use", 32'(use_a), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b1, 16'h0077, 1'b1);
    chk("empty_rw_use", 32'(use_a), 32'd1);
    chk("empty_rw_unf", 32'(unf_a), 32'd1);
    step(1'b1, 1'b0, 16'h0, 1'b0);

    // Wrap-around with occupancy kept between 2 and 5
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'(16'h0100 + i), 1'b0);
    for (int i = 3; i < 23; i++) begin
      if (i % 6 == 0)      step(1'b0, 1'b1, 16'(16'h0100 + i), 1'b0);
      else if (i % 6 == 3) step(1'b0, 1'b0, 16'h0, 1'b1);
      else                 step(1'b0, 1'b1, 16'(16'h0100 + i), 1'b1);
    end
    while (q.size() != 0) step(1'b0, 1'b0, 16'h0, 1'b1);

    // First-word fall-through
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    chk("fwft_valid", 32'(rd_valid_b), 32'd1);
    chk("fwft_data",  32'(rd_data_b),  32'h1234);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("fwft_pop_empty", 32'(empty_b),    32'd1);
    chk("fwft_pop_valid", 32'(rd_valid_b), 32'd0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("fwft_unf", 32'(unf_b), 32'd1);

    // Mid-operation reset discards the concurrent write
    step(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'(16'h0200 + i), 1'b0);
    step(1'b1, 1'b1, 16'h0099, 1'b0);
    chk("midrst_use",   32'(use_a),      32'd0);
    chk("midrst_valid", 32'(rd_valid_a), 32'd0);
    step(1'b0, 1'b1, 16'h00F0, 1'b0);
    chk("midrst_fw_head", 32'(rd_data_b), 32'h00F0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("midrst_readback", 32'(rd_data_a), 32'h00F0);

    // Randomised traffic with a drifting write bias to hit full and empty
    bias = 50;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) bias = int'($urandom_range(15, 85));
      step(($urandom_range(0, 79) == 0),
           (int'($urandom_range(0, 99)) < bias),
           16'($urandom),
           (int'($urandom_range(0, 99)) >= bias));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
